// File: rtl/csr_regfile_pkg.sv
// csr_regfile_pkg
//   Shared definitions for the machine-mode CSR block: data/address widths,
//   CSR address map, mstatus/mip bit positions, interrupt cause codes,
//   the misa default and a decode helper for implemented addresses.
package csr_regfile_pkg;

    localparam int XLEN       = 32;
    localparam int CSR_ADDR_W = 12;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

    // mstatus / mip / mie bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [XLEN-1:0] MIE_WMASK    = 32'h0000_0888;
    localparam logic [XLEN-1:0] MISA_DEFAULT = 32'h4000_0100;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    typedef enum logic [1:0] {
        IRQ_NONE,
        IRQ_MEI,
        IRQ_MSI,
        IRQ_MTI
    } irq_sel_e;

    function automatic logic csr_is_implemented(input logic [CSR_ADDR_W-1:0] addr);
        logic hit;
        hit = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_MHARTID: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [XLEN-1:0] irq_cause_word(input logic [3:0] code);
        return {1'b1, 27'b0, code};
    endfunction

endpackage

// File: rtl/csr_regfile_counter64.sv
// csr_counter64
//   64-bit free-running counter with an increment enable and independent
//   32-bit writes to the low and high halves. A write to either half takes
//   precedence over the increment for that cycle, so software sees exactly
//   the value it wrote on the following read.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   inc_en        count up by one this cycle
//   wr_lo, wr_hi  replace low / high 32 bits with wr_data
//   wr_data       write value
//   count         current 64-bit value
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 64'd0;
        end else if (wr_lo) begin
            count[31:0] <= wr_data;
        end else if (wr_hi) begin
            count[63:32] <= wr_data;
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile
//   Machine-mode CSR storage for the ID/EX stage. Provides a combinational
//   read of op_csr_addr, commits CSR writes at the clock edge, maintains the
//   mcycle/minstret counters, applies trap entry and mret updates, and
//   raises the pending-interrupt request.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   op_csr_addr, csr_rd_en/wr_en     CSR access of the current instruction
//   csr_write_data                   final write value
//   dest_csr_data, illegal_csr       combinational read data / access fault
//   instret_inc                      one instruction retired this cycle
//   trap_valid/cause/pc/tval         trap entry this cycle
//   mret                             return from trap this cycle
//   trap_target_pc, mepc_o           handler address, current mepc
//   irq_req, irq_cause               enabled pending interrupt and its cause
//   ext_irq, timer_irq, soft_irq     level interrupt lines
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [XLEN-1:0] HART_ID  = '0,
    parameter logic [XLEN-1:0] MISA_VAL = MISA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CSR_ADDR_W-1:0] op_csr_addr,
    input  logic                  csr_rd_en,
    input  logic                  csr_wr_en,
    input  logic [XLEN-1:0]       csr_write_data,
    output logic [XLEN-1:0]       dest_csr_data,
    output logic                  illegal_csr,
    input  logic                  instret_inc,
    input  logic                  trap_valid,
    input  logic [XLEN-1:0]       trap_cause,
    input  logic [XLEN-1:0]       trap_pc,
    input  logic [XLEN-1:0]       trap_tval,
    input  logic                  mret,
    output logic [XLEN-1:0]       trap_target_pc,
    output logic [XLEN-1:0]       mepc_o,
    output logic                  irq_req,
    output logic [XLEN-1:0]       irq_cause,
    input  logic                  ext_irq,
    input  logic                  timer_irq,
    input  logic                  soft_irq
);

    logic            mst_mie;
    logic            mst_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [63:0]     mcycle_q;
    logic [63:0]     minstret_q;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] pending;
    logic [XLEN-1:0] tvec_base;
    logic            implemented;
    logic            read_only;
    logic            csr_we;
    irq_sel_e        irq_sel;

    // MPP is hardwired to machine mode (2'b11); only MIE/MPIE are storage.
    assign mstatus_val = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
    assign mip_val     = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, soft_irq, 3'b0};

    // ---------------------------------------------------------------
    // Access decode
    // ---------------------------------------------------------------
    assign implemented = csr_is_implemented(op_csr_addr);
    assign read_only   = (op_csr_addr[11:10] == 2'b11)
                       | (op_csr_addr == CSR_MISA)
                       | (op_csr_addr == CSR_MIP);
    assign illegal_csr = ((csr_rd_en | csr_wr_en) & ~implemented)
                       | (csr_wr_en & read_only);

    // Trap and mret own the cycle; a coincident CSR write is dropped.
    assign csr_we = csr_wr_en & ~illegal_csr & ~trap_valid & ~mret;

    // ---------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------
    always_comb begin
        dest_csr_data = '0;
        case (op_csr_addr)
            CSR_MSTATUS:   dest_csr_data = mstatus_val;
            CSR_MISA:      dest_csr_data = MISA_VAL;
            CSR_MIE:       dest_csr_data = mie_q;
            CSR_MTVEC:     dest_csr_data = mtvec_q;
            CSR_MSCRATCH:  dest_csr_data = mscratch_q;
            CSR_MEPC:      dest_csr_data = mepc_q;
            CSR_MCAUSE:    dest_csr_data = mcause_q;
            CSR_MTVAL:     dest_csr_data = mtval_q;
            CSR_MIP:       dest_csr_data = mip_val;
            CSR_MCYCLE:    dest_csr_data = mcycle_q[31:0];
            CSR_MCYCLEH:   dest_csr_data = mcycle_q[63:32];
            CSR_MINSTRET:  dest_csr_data = minstret_q[31:0];
            CSR_MINSTRETH: dest_csr_data = minstret_q[63:32];
            CSR_MHARTID:   dest_csr_data = HART_ID;
            default:       dest_csr_data = '0;
        endcase
    end

    // ---------------------------------------------------------------
    // State update: reset > trap > mret > CSR write
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_valid) begin
            mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
        end else if (mret) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
        end else if (csr_we) begin
            case (op_csr_addr)
                CSR_MSTATUS: begin
                    mst_mie  <= csr_write_data[MSTATUS_MIE];
                    mst_mpie <= csr_write_data[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_q      <= csr_write_data & MIE_WMASK;
                // Reserved modes 2/3 collapse to direct mode.
                CSR_MTVEC:    mtvec_q    <= {csr_write_data[XLEN-1:2],
                                             (csr_write_data[1:0] == MTVEC_MODE_VECTORED)
                                                 ? MTVEC_MODE_VECTORED : MTVEC_MODE_DIRECT};
                CSR_MSCRATCH: mscratch_q <= csr_write_data;
                CSR_MEPC:     mepc_q     <= {csr_write_data[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   mcause_q   <= csr_write_data;
                CSR_MTVAL:    mtval_q    <= csr_write_data;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Counters
    // ---------------------------------------------------------------
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (1'b1),
        .wr_lo   (csr_we & (op_csr_addr == CSR_MCYCLE)),
        .wr_hi   (csr_we & (op_csr_addr == CSR_MCYCLEH)),
        .wr_data (csr_write_data),
        .count   (mcycle_q)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (instret_inc),
        .wr_lo   (csr_we & (op_csr_addr == CSR_MINSTRET)),
        .wr_hi   (csr_we & (op_csr_addr == CSR_MINSTRETH)),
        .wr_data (csr_write_data),
        .count   (minstret_q)
    );

    // ---------------------------------------------------------------
    // Trap vector
    // ---------------------------------------------------------------
    assign tvec_base      = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target_pc = ((mtvec_q[1:0] == MTVEC_MODE_VECTORED) && trap_cause[XLEN-1])
                          ? tvec_base + {25'b0, trap_cause[4:0], 2'b00}
                          : tvec_base;
    assign mepc_o         = mepc_q;

    // ---------------------------------------------------------------
    // Interrupt request: MEI > MSI > MTI
    // ---------------------------------------------------------------
    assign pending = mip_val & mie_q;
    assign irq_req = mst_mie & (|pending);

    always_comb begin
        irq_sel = IRQ_NONE;
        if (pending[MIP_MEIP])      irq_sel = IRQ_MEI;
        else if (pending[MIP_MSIP]) irq_sel = IRQ_MSI;
        else if (pending[MIP_MTIP]) irq_sel = IRQ_MTI;
    end

    always_comb begin
        irq_cause = '0;
        case (irq_sel)
            IRQ_MEI: irq_cause = irq_cause_word(IRQ_CODE_MEI);
            IRQ_MSI: irq_cause = irq_cause_word(IRQ_CODE_MSI);
            IRQ_MTI: irq_cause = irq_cause_word(IRQ_CODE_MTI);
            default: irq_cause = '0;
        endcase
    end

endmodule
